// File: rtl/prbs_pkg.sv
// Shared PRBS16 definitions: state encoding, Galois feedback mask and LFSR step.
// The generator and the checker both import this, so the polynomial lives in one place.
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } prbs_state_t;

    localparam logic [15:0] PRBS16_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] x, input logic [15:0] taps);
        return (x >> 1) ^ (x[0] ? taps : 16'h0000);
    endfunction

endpackage

// File: rtl/prbs16_checker_if.sv
// Sample stream into the PRBS16 checker and its lock/error status back out.
// The master drives samples; the slave (checker) returns registered status.
interface prbs16_checker_if #(
    parameter int ERR_WIDTH = 16
);
    logic [15:0]          din_dat;
    logic                 din_vld;
    logic                 clear_err;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_WIDTH-1:0] err_count;

    modport master (
        output din_dat, din_vld, clear_err,
        input  locked, err_pulse, err_count
    );

    modport slave (
        input  din_dat, din_vld, clear_err,
        output locked, err_pulse, err_count
    );
endinterface

// File: rtl/prbs16_checker.sv
// Purpose: acquire lock on a 16-bit Galois LFSR stream and count mismatches once locked.
// Latency: all outputs registered, updated on the edge that samples the valid DIN.
// Backpressure: none; a sample is consumed on every din_vld cycle, state holds otherwise.
module prbs16_checker
    import prbs_pkg::*;
#(
    parameter logic [15:0] TAPS       = PRBS16_TAPS,
    parameter int          LOCK_COUNT = 4,
    parameter int          LOSS_COUNT = 3,
    parameter int          ERR_WIDTH  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    prbs16_checker_if.slave  io_bus
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

    prbs_state_t          r_state;
    logic [15:0]          r_pred;
    logic [3:0]           r_match_cnt;
    logic [3:0]           r_miss_cnt;
    logic                 r_locked;
    logic                 r_err_pulse;
    logic [ERR_WIDTH-1:0] r_err_count;

    prbs_state_t          w_state;
    logic [15:0]          w_pred;
    logic [3:0]           w_match_cnt;
    logic [3:0]           w_miss_cnt;
    logic                 w_err;
    logic                 w_match;
    logic                 w_din_zero;

    assign w_match    = (io_bus.din_dat == r_pred);
    assign w_din_zero = (io_bus.din_dat == 16'h0000);

    always_comb begin
        w_state     = r_state;
        w_pred      = r_pred;
        w_match_cnt = r_match_cnt;
        w_miss_cnt  = r_miss_cnt;
        w_err       = 1'b0;
        if (io_bus.din_vld) begin
            case (r_state)
                HUNT: begin
                    if (!w_din_zero) begin
                        w_pred      = lfsr16_next(io_bus.din_dat, TAPS);
                        w_match_cnt = 4'd0;
                        w_state     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_match) begin
                        w_match_cnt = r_match_cnt + 4'd1;
                        w_pred      = lfsr16_next(io_bus.din_dat, TAPS);
                        if (w_match_cnt == LOCK_CNT) begin
                            w_state    = LOCK;
                            w_miss_cnt = 4'd0;
                        end
                    end else begin
                        // A mismatch reseeds from DIN; zero cannot seed, so fall back to HUNT
                        w_match_cnt = 4'd0;
                        if (w_din_zero) begin
                            w_state = HUNT;
                        end else begin
                            w_pred  = lfsr16_next(io_bus.din_dat, TAPS);
                            w_state = VERIFY;
                        end
                    end
                end
                LOCK: begin
                    w_pred = lfsr16_next(r_pred, TAPS);
                    if (w_match) begin
                        w_miss_cnt = 4'd0;
                    end else begin
                        w_err      = 1'b1;
                        w_miss_cnt = r_miss_cnt + 4'd1;
                        if (w_miss_cnt == LOSS_CNT) begin
                            w_state     = HUNT;
                            w_miss_cnt  = 4'd0;
                            w_match_cnt = 4'd0;
                        end
                    end
                end
                default: w_state = HUNT;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= HUNT;
            r_pred      <= 16'h0000;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state;
            r_pred      <= w_pred;
            r_match_cnt <= w_match_cnt;
            r_miss_cnt  <= w_miss_cnt;
            r_locked    <= (w_state == LOCK);
            r_err_pulse <= w_err;
            if (io_bus.clear_err) begin
                r_err_count <= '0;
            end else if (w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign io_bus.locked    = r_locked;
    assign io_bus.err_pulse = r_err_pulse;
    assign io_bus.err_count = r_err_count;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker (ERR_WIDTH = 4 so saturation is reachable).
module tb_prbs16_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] seq;

    always #5 clk = ~clk;

    prbs16_checker_if #(.ERR_WIDTH(4)) bus ();

    prbs16_checker #(.ERR_WIDTH(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    function automatic logic [15:0] step(input logic [15:0] x);
        logic [15:0] y;
        y = {1'b0, x[15:1]};
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    // Drive one cycle at the falling edge, return 1 ns after the rising edge.
    task automatic send(input logic [15:0] d, input logic v, input logic c);
        @(negedge clk);
        bus.din_dat   = d;
        bus.din_vld   = v;
        bus.clear_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.din_dat = 16'h0; bus.din_vld = 1'b0; bus.clear_err = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %b want 0", bus.locked); end
        n_cmp++; if (bus.err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse got %b want 0", bus.err_pulse); end
        n_cmp++; if (bus.err_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.err_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock_acquire();
        logic [15:0] vec [5];
        vec = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E};
        for (int i = 0; i < 4; i++) begin
            send(vec[i], 1'b1, 1'b0);
            n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL acq_early_lock sample %0d got %b want 0", i, bus.locked); end
        end
        send(vec[4], 1'b1, 1'b0);
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL acq_locked got %b want 1", bus.locked); end
        n_cmp++; if (bus.err_count !== 4'd0) begin n_bad++; $display("FAIL acq_count got %0d want 0", bus.err_count); end
    endtask

    task automatic test_single_error();
        send(16'h0000, 1'b1, 1'b0);
        n_cmp++; if (bus.err_pulse !== 1'b1) begin n_bad++; $display("FAIL single_pulse got %b want 1", bus.err_pulse); end
        n_cmp++; if (bus.err_count !== 4'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", bus.err_count); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL single_locked got %b want 1", bus.locked); end
        send(16'hB313, 1'b1, 1'b0);
        n_cmp++; if (bus.err_pulse !== 1'b0) begin n_bad++; $display("FAIL flywheel_pulse got %b want 0", bus.err_pulse); end
        n_cmp++; if (bus.err_count !== 4'd1) begin n_bad++; $display("FAIL flywheel_count got %0d want 1", bus.err_count); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL flywheel_locked got %b want 1", bus.locked); end
    endtask

    task automatic test_loss_of_lock();
        for (int i = 0; i < 3; i++) begin
            send(16'h1234, 1'b1, 1'b0);
            n_cmp++; if (bus.err_pulse !== 1'b1) begin n_bad++; $display("FAIL loss_pulse %0d got %b want 1", i, bus.err_pulse); end
            n_cmp++; if (bus.err_count !== 4'(2 + i)) begin n_bad++; $display("FAIL loss_count %0d got %0d want %0d", i, bus.err_count, 2 + i); end
            n_cmp++; if (bus.locked !== (i < 2)) begin n_bad++; $display("FAIL loss_locked %0d got %b want %b", i, bus.locked, (i < 2)); end
            send(16'h1234, 1'b0, 1'b0);
            n_cmp++; if (bus.err_pulse !== 1'b0) begin n_bad++; $display("FAIL loss_pulse_gap %0d got %b want 0", i, bus.err_pulse); end
        end
    endtask

    task automatic test_zero_seed_bubbles();
        logic [15:0] vec [4];
        vec = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E};
        send(16'h0000, 1'b1, 1'b0);
        send(16'hACE1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 5; b++) send(16'h5555, 1'b0, 1'b0);
            n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL bubble_lock_early %0d got %b want 0", i, bus.locked); end
            send(vec[i], 1'b1, 1'b0);
        end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL bubble_locked got %b want 1", bus.locked); end
        n_cmp++; if (bus.err_count !== 4'd4) begin n_bad++; $display("FAIL bubble_count got %0d want 4", bus.err_count); end
        for (int b = 0; b < 5; b++) send(16'h0000, 1'b0, 1'b0);
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL bubble_hold_lock got %b want 1", bus.locked); end
        send(16'h0E27, 1'b1, 1'b0);
        n_cmp++; if (bus.err_pulse !== 1'b0) begin n_bad++; $display("FAIL bubble_pred_held got pulse %b want 0", bus.err_pulse); end
        seq = 16'hB313;
    endtask

    task automatic test_saturation_clear();
        for (int i = 0; i < 20; i++) begin
            send(seq ^ 16'h0001, 1'b1, 1'b0);
            seq = step(seq);
            send(seq, 1'b1, 1'b0);
            seq = step(seq);
        end
        n_cmp++; if (bus.err_count !== 4'd15) begin n_bad++; $display("FAIL sat_count got %0d want 15", bus.err_count); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL sat_locked got %b want 1", bus.locked); end
        send(seq ^ 16'h8000, 1'b1, 1'b1);
        seq = step(seq);
        n_cmp++; if (bus.err_count !== 4'd0) begin n_bad++; $display("FAIL clear_count got %0d want 0", bus.err_count); end
        n_cmp++; if (bus.err_pulse !== 1'b1) begin n_bad++; $display("FAIL clear_pulse got %b want 1", bus.err_pulse); end
        send(seq, 1'b1, 1'b0);
        seq = step(seq);
        n_cmp++; if (bus.err_pulse !== 1'b0) begin n_bad++; $display("FAIL clear_pulse_width got %b want 0", bus.err_pulse); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL clear_locked got %b want 1", bus.locked); end
    endtask

    task automatic test_reset_mid_lock();
        logic [15:0] vec [5];
        vec = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E};
        send(seq ^ 16'h0100, 1'b1, 1'b0);
        n_cmp++; if (bus.err_count !== 4'd1) begin n_bad++; $display("FAIL pre_rst_count got %0d want 1", bus.err_count); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL rst_async_locked got %b want 0", bus.locked); end
        n_cmp++; if (bus.err_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_async_pulse got %b want 0", bus.err_pulse); end
        n_cmp++; if (bus.err_count !== 4'd0) begin n_bad++; $display("FAIL rst_async_count got %0d want 0", bus.err_count); end
        bus.din_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(vec[i], 1'b1, 1'b0);
            n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL relock_early %0d got %b want 0", i, bus.locked); end
        end
        send(vec[4], 1'b1, 1'b0);
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL relock got %b want 1", bus.locked); end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_single_error();
        test_loss_of_lock();
        test_zero_seed_bubbles();
        test_saturation_clear();
        test_reset_mid_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs16_checker.md
# prbs16_checker

Downstream consumer of the 16-bit Galois LFSR sequence generator. It accepts one 16-bit sample per valid cycle and predicts each next sample from the generator polynomial. It acquires and holds lock on the sequence, and counts mismatching samples once locked. It is used to verify the generator end-to-end and to detect corruption on the path between the generator and this block.

## Interface
- TAPS, 16'hB400, Galois feedback mask; next(x) = (x >> 1) ^ (x[0] ? TAPS : 16'h0000)
- LOCK_COUNT, 4, consecutive matches after the seed sample needed to lock; legal range 1..15
- LOSS_COUNT, 3, consecutive mismatches while locked that drop lock; legal range 1..15
- ERR_WIDTH, 16, width of the error counter
- CLK  input  1  clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- DIN  input  16  sample from the generator
- DIN_VALID  input  1  DIN is sampled on this edge
- CLEAR_ERR  input  1  synchronous clear of ERR_COUNT
- LOCKED  output  1  in LOCK state
- ERR_PULSE  output  1  one-cycle flag: the sample just taken mismatched while locked
- ERR_COUNT  output  ERR_WIDTH  saturating count of mismatches while locked

## Operation
- Reset values:
  - State = HUNT.
  - Prediction register = 0.
  - Match and miss counters = 0.
  - LOCKED = 0, ERR_PULSE = 0, ERR_COUNT = 0.
- All state changes occur only on edges where DIN_VALID = 1. With DIN_VALID = 0, everything holds, except that ERR_PULSE returns to 0 and CLEAR_ERR is still honoured.
- **HUNT**
  - DIN == 0 is ignored, because zero is the LFSR lockup value; stay in HUNT.
  - Any other DIN is the seed: pred <= next(DIN), match_cnt <= 0, go to VERIFY.
- **VERIFY**
  - If DIN == pred: match_cnt++, pred <= next(DIN). When the incremented count equals LOCK_COUNT, go to LOCK.
  - On a mismatch, DIN becomes the new seed (same rule as HUNT, including the zero rule, which returns to HUNT). match_cnt <= 0.
  - Errors are never counted in VERIFY.
- **LOCK**
  - pred <= next(pred) on every valid sample (flywheel). The block never reseeds from DIN while locked.
  - On a match: miss_cnt <= 0.
  - On a mismatch:
    - ERR_PULSE <= 1.
    - ERR_COUNT increments, saturating at all-ones.
    - miss_cnt++. When it reaches LOSS_COUNT, go to HUNT and clear miss_cnt and match_cnt.
  - The mismatch that causes loss of lock is still counted.
- CLEAR_ERR:
  - It has priority over a simultaneous increment: ERR_COUNT <= 0, but ERR_PULSE still fires for that sample.
  - It does not affect the state machine.
- ERR_COUNT is retained across loss of lock. Only RESET or CLEAR_ERR zero it.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- LOCKED rises on the edge that samples the LOCK_COUNT-th consecutive match, and is visible in the following cycle.
- LOCKED falls on the edge that samples the LOSS_COUNT-th consecutive mismatch.
- ERR_PULSE and the ERR_COUNT update appear on the same edge that samples the bad DIN. This is 1-cycle latency from the sample, and the pulse is exactly one cycle wide.
- Minimum time to lock = LOCK_COUNT + 1 valid samples, counting the seed.
- An asserted RESET at any time, including mid-lock, returns every register to its reset value immediately. The first valid sample after release is treated as a seed candidate.

## Structure
- Shared package `prbs_pkg` contains:
  - enum `prbs_state_t` {HUNT, VERIFY, LOCK};
  - localparam `PRBS16_TAPS` = 16'hB400;
  - function `lfsr16_next(x, taps)`.
- The generator and checker both use this package, so the polynomial is defined in one place.
- No sub-module is needed: a single always_ff plus an always_comb next-state block. The saturating counter may be inlined.

## Test plan
- Lock acquisition:
  - Stimulus: RESET, then valid samples 16'hACE1, E270, 7138, 389C, 1C4E on consecutive cycles.
  - Required: LOCKED = 0 through 389C, LOCKED = 1 the cycle after 1C4E is sampled, ERR_COUNT = 0.
- Single error while locked:
  - Stimulus: continue with 16'h0000 in place of 0E27, then B313.
  - Required: ERR_PULSE high for exactly one cycle, ERR_COUNT = 1, LOCKED stays 1, and B313 matches (flywheel advanced).
- Loss of lock:
  - Stimulus: while locked, feed three consecutive wrong samples (16'h1234 ×3).
  - Required: ERR_COUNT += 3 with three separate pulses; LOCKED = 0 after the third; state HUNT.
- Zero seed and bubbles:
  - Stimulus: in HUNT, feed 0000 then ACE1 with DIN_VALID low for 5 cycles between each subsequent sequence sample.
  - Required: zero is ignored, lock is still reached after the 4th match, and nothing advances during the bubbles.
- Saturation and clear (ERR_WIDTH = 4):
  - Stimulus: force 20 errors while keeping lock by interleaving matches, then assert CLEAR_ERR on the same cycle as a further error.
  - Required: ERR_COUNT holds at 15, then reads 0 with ERR_PULSE = 1.
- Reset mid-lock:
  - Stimulus: assert RESET asynchronously between clock edges while LOCKED = 1.
  - Required: LOCKED, ERR_PULSE and ERR_COUNT go to 0 immediately; re-lock needs a full seed plus 4 matches.
